// File: rtl/inst_fetch_unit_if.sv
// Bundle of signals that connects the instruction-fetch stage to its
// instruction memory, to the downstream decode stage and to the
// branch-resolution redirect path.
//
// Modports
//   master : the fetch unit. It drives the imem request and the decode-side
//            instruction outputs. It receives imem ready/response, the
//            redirect and inst_ready.
//   slave  : the environment (memory, decode and branch unit), which sees the
//            mirror image of the master modport.
//
// Signals
//   imem_req_valid / imem_req_ready / imem_req_addr : fetch request handshake
//   imem_rsp_valid / imem_rsp_data                  : in-order returned words
//   redirect_valid / redirect_pc                    : taken branch/jump
//   inst_valid / inst_ready / inst / inst_pc        : FIFO head towards decode
interface inst_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Decoupled instruction-fetch stage. The unit issues sequential word fetches
// to an instruction memory that has variable latency. Returned words are
// buffered with their PCs in a prefetch FIFO. On a redirect from downstream,
// the unit flushes the FIFO and restarts fetching at the new target.
//
// Parameters
//   DEPTH    : prefetch FIFO entries (power of 2, >= 2). This is also the cap
//              on count + outstanding requests.
//   RESET_PC : word-aligned fetch address after reset.
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : inst_fetch_unit_if.master (imem request/response, redirect, and the
//         decode-side instruction head)
module inst_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rst_hold;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [CW:0]   credits_used;
    logic [CW-1:0] outstanding_nxt;
    logic [31:0]   redirect_aligned;

    // Credit check uses only registered occupancy, so a pop in this cycle does
    // not allow a new request until the next cycle. rst_hold keeps the request
    // line low for one extra cycle after reset.
    assign credits_used       = {1'b0, count} + {1'b0, outstanding};
    assign bus.imem_req_valid = !rst && !rst_hold && (state == FETCH) &&
                                !bus.redirect_valid && (credits_used < DEPTH_W);
    assign bus.imem_req_addr  = fetch_pc;

    // A response that arrives with nothing outstanding is a protocol error
    // and is ignored. Only FETCH-state responses with nothing left to drop
    // are buffered.
    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire   = bus.imem_rsp_valid && (outstanding != '0);
    assign push       = rsp_fire && (state == FETCH) && (drop_cnt == '0) &&
                        !bus.redirect_valid;
    assign head_valid = !rst && (count != '0);
    assign pop        = head_valid && bus.inst_ready;

    assign outstanding_nxt  = outstanding + CW'(req_fire) - CW'(rsp_fire);
    assign redirect_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

    assign bus.inst_valid = head_valid;
    assign bus.inst       = head_valid ? word_q[rd_ptr] : '0;
    assign bus.inst_pc    = head_valid ? pc_q[rd_ptr]   : '0;

    // FIFO storage has no reset: the pointers and count define which entries
    // are meaningful.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            word_q[wr_ptr] <= bus.imem_rsp_data;
            pc_q[wr_ptr]   <= rsp_pc;
        end
    end

    // Control state. A redirect overrides everything else. Whatever is still
    // in flight after the redirect becomes the drop count, so DRAIN always
    // has exactly as many stale responses to swallow as there are requests
    // outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rst_hold    <= 1'b1;
        end else begin
            rst_hold    <= 1'b0;
            outstanding <= outstanding_nxt;
            if (bus.redirect_valid) begin
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                drop_cnt <= outstanding_nxt;
                state    <= (outstanding_nxt != '0) ? DRAIN : FETCH;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
                if ((state == DRAIN) && rsp_fire) begin
                    drop_cnt <= drop_cnt - CW'(1);
                    if (drop_cnt == CW'(1)) begin
                        state <= FETCH;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit. A memory model with configurable latency
// serves requests in order. The reference model tracks the expected fetch
// stream, FIFO occupancy and stale responses using plain counters and a
// queue, and checks the DUT every cycle.
module tb_inst_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          s_cyc = 0;
    int          n_pops = 0;
    int          m_cnt = 0;
    int          m_stale = 0;
    logic        m_hold = 1'b0;
    logic        cur_rsp_real = 1'b0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_req = RESET_PC;
    int          lat_min = 1;
    int          lat_max = 1;
    int          req_pct = 100;
    int          inst_pct = 100;
    logic        s_req_valid, s_acc, s_inst_valid;
    logic [31:0] s_req_addr, s_inst, s_inst_pc;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: sample at the falling edge, check against the model,
    // advance the model, then drive the next cycle's inputs after the rising
    // edge.
    task automatic tick();
        logic  exp_rv, exp_iv, pop_m;
        int    outst;
        pend_t p;
        @(negedge clk);
        s_cyc        = cyc;
        s_req_valid  = bus.imem_req_valid;
        s_req_addr   = bus.imem_req_addr;
        s_inst_valid = bus.inst_valid;
        s_inst       = bus.inst;
        s_inst_pc    = bus.inst_pc;
        s_acc        = s_req_valid && bus.imem_req_ready;
        outst  = pend.size() + (cur_rsp_real ? 1 : 0);
        exp_rv = !rst && !m_hold && !bus.redirect_valid && (m_stale == 0) &&
                 (m_cnt + outst < DEPTH);
        exp_iv = !rst && (m_cnt != 0);
        n_cmp++;
        if (s_req_valid !== exp_rv) begin
            n_fail++;
            $display("[TB] FAIL req_valid cyc %0d got %b exp %b", cyc, s_req_valid, exp_rv);
        end
        n_cmp++;
        if (s_inst_valid !== exp_iv) begin
            n_fail++;
            $display("[TB] FAIL inst_valid cyc %0d got %b exp %b", cyc, s_inst_valid, exp_iv);
        end
        if (s_req_valid && exp_rv) begin
            n_cmp++;
            if (s_req_addr !== exp_req) begin
                n_fail++;
                $display("[TB] FAIL req_addr cyc %0d got %h exp %h", cyc, s_req_addr, exp_req);
            end
        end
        if (rst) begin
            pend.delete();
            m_cnt   = 0;
            m_stale = 0;
            m_hold  = 1'b1;
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
        end else begin
            m_hold = 1'b0;
            pop_m  = exp_iv && bus.inst_ready;
            if (s_inst_valid && exp_iv && bus.inst_ready) begin
                n_cmp++;
                if (s_inst_pc !== exp_pc || s_inst !== mem_fn(exp_pc)) begin
                    n_fail++;
                    $display("[TB] FAIL pop cyc %0d got pc %h inst %h exp pc %h inst %h",
                             cyc, s_inst_pc, s_inst, exp_pc, mem_fn(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                n_pops++;
            end
            if (bus.redirect_valid) begin
                m_cnt   = 0;
                m_stale = pend.size();
                exp_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
                exp_req = bus.redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (cur_rsp_real) begin
                    if (m_stale > 0) m_stale--;
                    else m_cnt++;
                end
                if (pop_m) m_cnt--;
                if (s_acc) exp_req = exp_req + 32'd4;
            end
            if (s_acc) begin
                p.addr = s_req_addr;
                p.due  = cyc + int'($urandom_range(lat_max, lat_min));
                pend.push_back(p);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = ($urandom_range(99, 0) < req_pct);
        bus.inst_ready     = ($urandom_range(99, 0) < inst_pct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_fn(p.addr);
            cur_rsp_real       = 1'b1;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
            cur_rsp_real       = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        tick();
        n_cmp++;
        if (s_inst !== 32'h0 || s_inst_pc !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_inst got %h/%h exp 0/0", s_inst, s_inst_pc);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b0 || s_inst !== 32'h0 || s_inst_pc !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold got req %b inst %h pc %h exp 0", s_req_valid, s_inst, s_inst_pc);
        end
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
            n_fail++;
            $display("[TB] FAIL first_req got %b/%h exp 1/%h", s_req_valid, s_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int first_acc = -1;
        int first_iv = -1;
        int pops0;
        $display("[TB] test_stream");
        lat_min = 1; lat_max = 1; req_pct = 100; inst_pct = 100;
        do_reset();
        pops0 = n_pops;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_acc && first_acc < 0) first_acc = s_cyc;
            if (s_inst_valid && first_iv < 0) first_iv = s_cyc;
        end
        n_cmp++;
        if (first_acc < 0 || first_iv - first_acc != 2) begin
            n_fail++;
            $display("[TB] FAIL stream_latency got %0d exp 2", first_iv - first_acc);
        end
        n_cmp++;
        if (n_pops - pops0 < 20) begin
            n_fail++;
            $display("[TB] FAIL stream_throughput got %0d pops exp >=20", n_pops - pops0);
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        $display("[TB] test_backpressure");
        lat_min = 1; lat_max = 1; req_pct = 100; inst_pct = 0;
        do_reset();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_acc) n_acc++;
        end
        n_cmp++;
        if (n_acc != DEPTH || s_req_valid !== 1'b0 || s_inst_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL full_fifo got acc %0d req %b iv %b exp 4/0/1", n_acc, s_req_valid, s_inst_valid);
        end
        bus.inst_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h10) begin
            n_fail++;
            $display("[TB] FAIL refill_req got %b/%h exp 1/00000010", s_req_valid, s_req_addr);
        end
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL refill_stop got %b exp 0", s_req_valid);
        end
    endtask

    task automatic test_redirect_drain();
        int  guard;
        logic seen;
        $display("[TB] test_redirect_drain");
        lat_min = 6; lat_max = 6; req_pct = 100; inst_pct = 100;
        do_reset();
        guard = 0;
        while (pend.size() < 3 && guard < 20) begin
            tick();
            guard++;
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL redirect_noreq got %b exp 0", s_req_valid);
        end
        guard = 0;
        while (pend.size() > 0 && guard < 30) begin
            tick();
            guard++;
            n_cmp++;
            if (s_inst_valid !== 1'b0 || s_req_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL drain_quiet got iv %b req %b exp 0/0", s_inst_valid, s_req_valid);
            end
        end
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drain_last got %b exp 0", s_req_valid);
        end
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
            n_fail++;
            $display("[TB] FAIL drain_exit got %b/%h exp 1/00000100", s_req_valid, s_req_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (s_inst_valid) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || s_inst_pc !== 32'h100) begin
            n_fail++;
            $display("[TB] FAIL target_inst got seen %b pc %h exp 1/00000100", seen, s_inst_pc);
        end
    endtask

    task automatic test_redirect_same_rsp();
        int guard;
        $display("[TB] test_redirect_same_rsp");
        lat_min = 2; lat_max = 2; req_pct = 100; inst_pct = 100;
        do_reset();
        guard = 0;
        while (!cur_rsp_real && guard < 10) begin
            tick();
            guard++;
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL samecyc_noreq got %b exp 0", s_req_valid);
        end
        tick();
        n_cmp++;
        if (s_inst_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL samecyc_dropped got %b exp 0", s_inst_valid);
        end
        guard = 0;
        while (!s_acc && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (!s_acc || s_req_addr !== 32'h100) begin
            n_fail++;
            $display("[TB] FAIL samecyc_req got %b/%h exp 1/00000100", s_acc, s_req_addr);
        end
    endtask

    task automatic test_req_stall();
        int pops0;
        $display("[TB] test_req_stall");
        lat_min = 1; lat_max = 1; req_pct = 0; inst_pct = 100;
        do_reset();
        bus.imem_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.imem_req_ready = 1'b0;
            tick();
            n_cmp++;
            if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC || s_inst_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall got req %b addr %h iv %b exp 1/%h/0", s_req_valid, s_req_addr, s_inst_valid, RESET_PC);
            end
        end
        req_pct = 100;
        bus.imem_req_ready = 1'b1;
        pops0 = n_pops;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (n_pops - pops0 < 5) begin
            n_fail++;
            $display("[TB] FAIL stall_resume got %0d pops exp >=5", n_pops - pops0);
        end
    endtask

    task automatic test_reset_mid();
        int   guard;
        logic seen;
        $display("[TB] test_reset_mid");
        lat_min = 3; lat_max = 3; req_pct = 100; inst_pct = 0;
        do_reset();
        bus.inst_ready = 1'b0;
        guard = 0;
        while (!((pend.size() + (cur_rsp_real ? 1 : 0)) == 2 && m_cnt == 2) && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (guard >= 20) begin
            n_fail++;
            $display("[TB] FAIL midreset_setup got timeout exp 2 outstanding/2 buffered");
        end
        do_reset();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        cur_rsp_real       = 1'b0;
        tick();
        n_cmp++;
        if (s_inst_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_empty got %b exp 0", s_inst_valid);
        end
        inst_pct = 100;
        bus.inst_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (s_inst_valid) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || s_inst_pc !== RESET_PC || s_inst !== mem_fn(RESET_PC)) begin
            n_fail++;
            $display("[TB] FAIL midreset_restart got seen %b pc %h inst %h exp 1/%h/%h", seen, s_inst_pc, s_inst, RESET_PC, mem_fn(RESET_PC));
        end
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        lat_min = 1; lat_max = 4; req_pct = 70; inst_pct = 60;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (i == 10) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'hFFFF_FFF9;
            end else if ($urandom_range(99, 0) < 3) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = $urandom;
            end
        end
        req_pct = 100; inst_pct = 100;
        for (int i = 0; i < 40; i++) tick();
    endtask

    initial begin
        rst                = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_same_rsp();
        test_req_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
